// File: rtl/sdp_byte_ram_pkg.sv
// Shared definitions for sdp_byte_ram: clear FSM states, storage lane geometry and parity helper.
// Lane geometry depends on RAM_PARITY_EN (one even-parity bit per byte lane when defined).
package sdp_byte_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

`ifdef RAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    localparam int LANE_W = 8 + PAR_W;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sdp_ram_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once, writing zero, then parks in READY.
module sdp_ram_clear_ctrl
    import sdp_byte_ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  init_busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam ram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    ram_state_e state_q, state_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_busy = 1'b0;
        clr_we    = 1'b0;
        clr_addr  = cnt_q[ADDR_WIDTH-1:0];
        case (state_q)
            ST_CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
                cnt_d     = cnt_q + CNT_ONE;
                // Carry into the extra MSB means the last address is being written now.
                if (cnt_d[ADDR_WIDTH]) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

endmodule

// File: rtl/sdp_byte_ram.sv
// Simple dual-port byte-writable RAM with clear sequencer, 1/2-cycle read latency and
// selectable read-during-write; optional per-lane parity under `define RAM_PARITY_EN.
module sdp_byte_ram
    import sdp_byte_ram_pkg::*;
#(
    parameter int  DATA_WIDTH     = 32,
    parameter int  ADDR_WIDTH     = 10,
    parameter int  READ_LATENCY   = 1,
    parameter int  RDW_NEW_DATA   = 1,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int BYTES          = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  init_busy,
    input  logic                  we,
    input  logic [BYTES-1:0]      be,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic                  par_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int MEM_W = BYTES * LANE_W;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH <= 0) begin : g_bad_width
        $error("sdp_byte_ram: DATA_WIDTH must be a positive multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sdp_byte_ram: READ_LATENCY must be 1 or 2");
    end

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    sdp_ram_clear_ctrl #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .clk      (clk),
        .reset_n  (reset_n),
        .init_busy(init_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic [MEM_W-1:0] mem [DEPTH];

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BYTES-1:0]      wr_be;
    logic [MEM_W-1:0]      wr_word;
    logic [7:0]            lane_data;

    always_comb begin
        wr_en     = clr_we | (we & ~init_busy);
        wr_addr   = clr_we ? clr_addr : waddr;
        wr_be     = clr_we ? {BYTES{1'b1}} : be;
        wr_word   = '0;
        lane_data = '0;
        for (int i = 0; i < BYTES; i++) begin
            lane_data                = clr_we ? 8'h00 : d[i*8 +: 8];
            wr_word[i*LANE_W +: 8]   = lane_data;
`ifdef RAM_PARITY_EN
            wr_word[i*LANE_W + 8]    = byte_parity(lane_data);
`endif
        end
    end

    // NOTE: the array has no reset; only the clear sequencer zeroes it, which keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*LANE_W +: LANE_W] <= wr_word[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    logic             rd_en;
    logic [MEM_W-1:0] rd_word;
    logic [MEM_W-1:0] rd_word_q, rd_word_d;
    logic             rd_valid_q, rd_valid_d;

    always_comb begin
        rd_en   = re & ~init_busy;
        rd_word = mem[raddr];
        // Same-address bypass: written lanes come from the write port, the rest from the array.
        if (RDW_NEW_DATA != 0 && wr_en && wr_addr == raddr) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) begin
                    rd_word[i*LANE_W +: LANE_W] = wr_word[i*LANE_W +: LANE_W];
                end
            end
        end
        rd_word_d  = rd_en ? rd_word : rd_word_q;
        rd_valid_d = rd_en;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_word_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_word_q  <= rd_word_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    logic [MEM_W-1:0] out_word;
    logic             out_valid;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [MEM_W-1:0] out_word_q, out_word_d;
        logic             out_valid_q, out_valid_d;

        always_comb begin
            out_word_d  = rd_valid_q ? rd_word_q : out_word_q;
            out_valid_d = rd_valid_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_word_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_word_q  <= out_word_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign out_word  = out_word_q;
        assign out_valid = out_valid_q;
    end else begin : g_lat1
        assign out_word  = rd_word_q;
        assign out_valid = rd_valid_q;
    end

    always_comb begin
        q       = '0;
        par_err = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            q[i*8 +: 8] = out_word[i*LANE_W +: 8];
`ifdef RAM_PARITY_EN
            if (byte_parity(out_word[i*LANE_W +: 8]) != out_word[i*LANE_W + 8]) begin
                par_err = out_valid;
            end
`endif
        end
        q_valid = out_valid;
    end

endmodule
